// File: rtl/rob_recovery_walker_pkg.sv
// Shared Falco core types used by the ROB and the pipeline controller.
// Holds the ROB tag type and the recovery-walker state encoding.
package Falco_pkg;

    localparam int FALCO_ROB_DEPTH = 32;
    localparam int FALCO_ROB_TAG_W = $clog2(FALCO_ROB_DEPTH);

    typedef logic [FALCO_ROB_TAG_W-1:0] rob_tag_t;

    typedef enum logic [1:0] {
        RW_IDLE = 2'd0,
        RW_WALK = 2'd1,
        RW_DONE = 2'd2
    } rob_walk_state_t;

endpackage

// File: rtl/rob_recovery_walker.sv
// ROB recovery walker: walks squashed entries from youngest to oldest, two per
// cycle, then reports the restored tail with a one-cycle finished pulse.
module rob_recovery_walker
    import Falco_pkg::*;
#(
    parameter int ROB_DEPTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         recovery_start,
    input  logic [$clog2(ROB_DEPTH)-1:0] recovery_target_tag,
    input  logic [$clog2(ROB_DEPTH)-1:0] rob_tail,
    input  logic                         recovery_stall,
    output logic [$clog2(ROB_DEPTH)-1:0] flush_rob_tag_0,
    output logic [$clog2(ROB_DEPTH)-1:0] flush_rob_tag_1,
    output logic                         flush_rob_tag_0_valid,
    output logic                         flush_rob_tag_1_valid,
    output logic                         ROB_recovery_finished,
    output logic [$clog2(ROB_DEPTH)-1:0] tail_restore_tag,
    output logic                         recovery_busy
);

    localparam int TAG_W = $clog2(ROB_DEPTH);
    localparam logic [TAG_W-1:0] TAG_ZERO = {TAG_W{1'b0}};
    localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
    localparam logic [TAG_W-1:0] TAG_TWO  = TAG_W'(2);

    rob_walk_state_t  state_r;
    rob_walk_state_t  state_s;
    logic [TAG_W-1:0] cur_r;
    logic [TAG_W-1:0] cur_s;
    logic [TAG_W-1:0] remain_r;
    logic [TAG_W-1:0] remain_s;
    logic [TAG_W-1:0] restore_r;
    logic [TAG_W-1:0] restore_s;
    logic [TAG_W-1:0] remain_start_s;
    logic             walk_active_s;

    // Next-state, walk pointer and remaining-count computation.
    always_comb begin
        state_s        = state_r;
        cur_s          = cur_r;
        remain_s       = remain_r;
        restore_s      = restore_r;
        // Entries strictly between target and tail; wraps naturally in TAG_W bits.
        remain_start_s = rob_tail - recovery_target_tag - TAG_ONE;
        case (state_r)
            RW_IDLE: begin
                if (recovery_start) begin
                    cur_s     = rob_tail - TAG_ONE;
                    restore_s = recovery_target_tag + TAG_ONE;
                    remain_s  = remain_start_s;
                    if (remain_start_s == TAG_ZERO) begin
                        state_s = RW_DONE;
                    end else begin
                        state_s = RW_WALK;
                    end
                end else begin
                    state_s = RW_IDLE;
                end
            end
            RW_WALK: begin
                if (!recovery_stall) begin
                    cur_s = cur_r - TAG_TWO;
                    if (remain_r <= TAG_TWO) begin
                        remain_s = TAG_ZERO;
                        state_s  = RW_DONE;
                    end else begin
                        remain_s = remain_r - TAG_TWO;
                        state_s  = RW_WALK;
                    end
                end else begin
                    state_s = RW_WALK;
                end
            end
            RW_DONE: begin
                state_s = RW_IDLE;
            end
            default: begin
                state_s = RW_IDLE;
            end
        endcase
    end

    // State and walk-context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= RW_IDLE;
            cur_r     <= TAG_ZERO;
            remain_r  <= TAG_ZERO;
            restore_r <= TAG_ZERO;
        end else begin
            state_r   <= state_s;
            cur_r     <= cur_s;
            remain_r  <= remain_s;
            restore_r <= restore_s;
        end
    end

    // Output decode from registered state; stall masks the lanes in the cycle it is raised.
    always_comb begin
        walk_active_s         = (state_r == RW_WALK) && !recovery_stall;
        flush_rob_tag_0       = TAG_ZERO;
        flush_rob_tag_1       = TAG_ZERO;
        flush_rob_tag_0_valid = 1'b0;
        flush_rob_tag_1_valid = 1'b0;
        ROB_recovery_finished = 1'b0;
        tail_restore_tag      = TAG_ZERO;
        recovery_busy         = (state_r != RW_IDLE);
        if (state_r == RW_WALK) begin
            flush_rob_tag_0       = cur_r;
            flush_rob_tag_1       = cur_r - TAG_ONE;
            flush_rob_tag_0_valid = walk_active_s;
            flush_rob_tag_1_valid = walk_active_s && (remain_r >= TAG_TWO);
        end else if (state_r == RW_DONE) begin
            ROB_recovery_finished = 1'b1;
            tail_restore_tag      = restore_r;
        end else begin
            ROB_recovery_finished = 1'b0;
        end
    end

endmodule

// File: doc/rob_recovery_walker.md
# rob_recovery_walker

ROB-side responder to the pipeline controller's recovery protocol. On `recovery_start` it snapshots the ROB tail and the tag of the mispredicting (oldest surviving) instruction. It then walks backward from youngest to oldest, emitting up to two squashed ROB tags per cycle on the `flush_rob_tag_*` lanes so rename can roll back mappings and the free list. When the walk completes it pulses `ROB_recovery_finished` and presents the restored tail.

## Interface
Parameters:
- `ROB_DEPTH`, default 32: number of ROB entries; power of two; `rob_tag_t` width = log2(`ROB_DEPTH`).

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `recovery_start`  in  1  single-cycle pulse from the controller; begins a walk.
- `recovery_target_tag`  in  `rob_tag_t`  tag of the mispredicting or violating instruction; sampled with `recovery_start`; survives the flush.
- `rob_tail`  in  `rob_tag_t`  current ROB tail (next free slot); sampled with `recovery_start`.
- `recovery_stall`  in  1  freezes walk progress for this cycle.
- `flush_rob_tag_0`  out  `rob_tag_t`  younger squashed tag of this cycle.
- `flush_rob_tag_1`  out  `rob_tag_t`  older squashed tag of this cycle.
- `flush_rob_tag_0_valid`  out  1  lane 0 valid.
- `flush_rob_tag_1_valid`  out  1  lane 1 valid.
- `ROB_recovery_finished`  out  1  one-cycle pulse when the walk is done.
- `tail_restore_tag`  out  `rob_tag_t`  new tail = target+1; meaningful when finished is high.
- `recovery_busy`  out  1  high from the cycle after start until the finished pulse, inclusive.

## Operation
- States are IDLE, WALK and DONE.
- Reset value of every output is 0. Reset also forces state to IDLE.
- IDLE:
  - On `recovery_start`, latch `cur = rob_tail - 1` and `target = recovery_target_tag`.
  - Compute `remain = (rob_tail - recovery_target_tag - 1) mod ROB_DEPTH`. `remain` is log2(`ROB_DEPTH`) bits wide; the maximum is `ROB_DEPTH`-1.
  - If `remain` == 0, go to DONE. Otherwise go to WALK.
- WALK, with `recovery_stall` low:
  - Lane 0 = `cur`, valid.
  - Lane 1 = `cur - 1`, valid only if `remain` >= 2.
  - Then `cur -= 2` and `remain -= min(2, remain)`.
  - When `remain` reaches 0 in this cycle, go to DONE.
- WALK, with `recovery_stall` high: both valids 0; no state or counter change.
- DONE:
  - Assert `ROB_recovery_finished` and `tail_restore_tag = target + 1` for one cycle, then return to IDLE.
  - `recovery_stall` is ignored in DONE.
- All tag arithmetic is modulo `ROB_DEPTH`, i.e. natural wrap of `rob_tag_t`. Wrap from tag 0 to `ROB_DEPTH`-1 is seamless within a single cycle's lane pair.
- `recovery_start` while not in IDLE is ignored. The controller guarantees one recovery at a time; the bench checks that a start during a walk is dropped.
- `recovery_start` on the same cycle as DONE is also ignored.
- Lanes are ordered youngest first. A tag is never emitted twice, and `target` is never emitted.

## Timing
- Start sampled in cycle N. First flush lanes are valid in N+1 (registered outputs).
- K squashed entries with no stalls: walk occupies N+1 .. N+ceil(K/2). Finished pulses at N+ceil(K/2)+1.
- K = 0: finished at N+1, with no valid lanes ever.
- Each stall cycle delays all subsequent events by exactly one cycle.
- Asynchronous reset mid-walk immediately clears the state, the valids and finished. No partial pulse follows reset deassertion.
- Throughput: 2 tags/cycle. Worst case (K = `ROB_DEPTH`-1 = 31) takes 16 walk cycles + 1 done cycle.

## Structure
- `rob_tag_t` stays in `Falco_pkg`.
- Add `rob_walk_state_t` (IDLE/WALK/DONE) to `Falco_pkg` for visibility in the controller's debug taps.
- Single flat module; no sub-module is warranted. The lane-pair generator is a few lines of subtraction.
- Intended to sit inside the ROB and drive the ROB modport outputs of the recovery interface.

## Test plan
- tail=10, target=4, start at N → K=5:
  - N+1: lanes (9,8) valid.
  - N+2: (7,6).
  - N+3: 5, lane 1 invalid.
  - N+4: finished=1, tail_restore=5.
- Wrap, DEPTH 32: tail=2, target=29 → K=4:
  - N+1: (1,0).
  - N+2: (31,30).
  - N+3: finished, tail_restore=30.
- Empty walk: tail=7, target=6 → no valid lanes; finished at N+1, tail_restore=7.
- Stall: tail=10, target=4, `recovery_stall` high in N+2 only:
  - N+2: lanes invalid.
  - (7,6) at N+3, 5 at N+4, finished at N+5.
- Busy drop: second start in N+2 with target=0 → ignored; original sequence is unchanged.
- Reset: `rst_n` low in N+2 of a K=5 walk → all outputs 0 in that cycle. After release there are no lanes and no finished pulse; a new start then behaves normally.
